// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - shared single-port SRAM arbiter: instruction fetch vs. data read/write
// Optional write protection of the low 16 KiB region when IMEM_WR_PROTECT_EN is defined.
module imem_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] pc_i,
  input  logic        flush_i,
  output logic [15:0] instr_o,
  output logic        stall_pc_o,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_wdata_o,
  input  logic [15:0] ram_rdata_i,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o
`ifdef IMEM_WR_PROTECT_EN
  ,
  output logic        wp_err_o
`endif
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    D_RD       = 2'd1,
    D_WR_SETUP = 2'd2,
    D_WR_PULSE = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_instr;
  logic [15:0] r_mem_rdata;
  logic        r_mem_done;
  logic        w_wr_blocked;
  logic        w_is_write;

`ifdef IMEM_WR_PROTECT_EN
  logic        r_wp_err;
  assign w_wr_blocked = (mem_addr_i < 16'h4000);
  assign wp_err_o     = r_wp_err;
`else
  assign w_wr_blocked = 1'b0;
`endif

  assign w_is_write  = (r_state == D_WR_SETUP) || (r_state == D_WR_PULSE);

  assign instr_o     = r_instr;
  assign mem_rdata_o = r_mem_rdata;
  assign mem_done_o  = r_mem_done;

  // Strobes are gated by reset so an interrupted write pulse is abandoned immediately.
  always_comb begin
    ram_addr_o  = (r_state == FETCH) ? pc_i : mem_addr_i;
    ram_wdata_o = w_is_write ? mem_wdata_i : 16'h0000;
    ram_oe_n_o  = w_is_write;
    ram_we_n_o  = 1'b1;
    if (RST && (r_state == D_WR_PULSE) && !w_wr_blocked) begin
      ram_we_n_o = 1'b0;
    end
    stall_pc_o  = !RST || (r_state != FETCH) || mem_rd_i || mem_wr_i;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= FETCH;
      r_instr     <= NOP;
      r_mem_rdata <= 16'h0000;
      r_mem_done  <= 1'b0;
`ifdef IMEM_WR_PROTECT_EN
      r_wp_err    <= 1'b0;
`endif
    end else begin
      r_mem_done <= 1'b0;
`ifdef IMEM_WR_PROTECT_EN
      r_wp_err   <= 1'b0;
`endif
      case (r_state)
        FETCH: begin
          if (mem_wr_i) begin
            r_state <= D_WR_SETUP;
            r_instr <= NOP;
          end else if (mem_rd_i) begin
            r_state <= D_RD;
            r_instr <= NOP;
          end else if (flush_i) begin
            r_instr <= NOP;
          end else begin
            r_instr <= ram_rdata_i;
          end
        end
        D_RD: begin
          r_mem_rdata <= ram_rdata_i;
          r_mem_done  <= 1'b1;
          r_instr     <= NOP;
          r_state     <= FETCH;
        end
        D_WR_SETUP: begin
          r_instr <= NOP;
          r_state <= D_WR_PULSE;
        end
        D_WR_PULSE: begin
          r_mem_done <= 1'b1;
`ifdef IMEM_WR_PROTECT_EN
          r_wp_err   <= w_wr_blocked;
`endif
          r_instr    <= NOP;
          r_state    <= FETCH;
        end
        default: begin
          r_state <= FETCH;
          r_instr <= NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed self-checking bench for imem_ctrl
module tb_imem_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] pc_i;
  logic        flush_i;
  logic [15:0] instr_o;
  logic        stall_pc_o;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_wdata_i;
  logic [15:0] mem_rdata_o;
  logic        mem_done_o;
  logic [15:0] ram_addr_o;
  logic [15:0] ram_wdata_o;
  logic [15:0] ram_rdata_i;
  logic        ram_oe_n_o;
  logic        ram_we_n_o;
`ifdef IMEM_WR_PROTECT_EN
  logic        wp_err_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  imem_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc_i        (pc_i),
    .flush_i     (flush_i),
    .instr_o     (instr_o),
    .stall_pc_o  (stall_pc_o),
    .mem_rd_i    (mem_rd_i),
    .mem_wr_i    (mem_wr_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_done_o  (mem_done_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_oe_n_o  (ram_oe_n_o),
    .ram_we_n_o  (ram_we_n_o)
`ifdef IMEM_WR_PROTECT_EN
    ,
    .wp_err_o    (wp_err_o)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; pc_i = 16'h0010; flush_i = 1'b0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = 16'h0000; mem_wdata_i = 16'h0000;
    ram_rdata_i = 16'h0000;
    tick(); tick();
    chk("rst_instr", instr_o, 16'h0800);
    chk("rst_rdata", mem_rdata_o, 16'h0000);
    chk("rst_done", {15'd0, mem_done_o}, 16'd0);
    chk("rst_stall", {15'd0, stall_pc_o}, 16'd1);
    chk("rst_we_n", {15'd0, ram_we_n_o}, 16'd1);

    // fetch after reset
    RST = 1'b1; ram_rdata_i = 16'h1234; #1;
    chk("fetch_addr", ram_addr_o, 16'h0010);
    chk("fetch_oe_n", {15'd0, ram_oe_n_o}, 16'd0);
    chk("fetch_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("fetch_wdata", ram_wdata_o, 16'h0000);
    chk("fetch_stall", {15'd0, stall_pc_o}, 16'd0);
    tick();
    chk("fetch_instr", instr_o, 16'h1234);
    chk("fetch_stall2", {15'd0, stall_pc_o}, 16'd0);

    // flush
    flush_i = 1'b1; ram_rdata_i = 16'h17FF; tick();
    chk("flush_instr", instr_o, 16'h0800);
    flush_i = 1'b0; tick();
    chk("unflush_instr", instr_o, 16'h17FF);

    // data read
    mem_rd_i = 1'b1; mem_addr_i = 16'h8000; #1;
    chk("rd_req_stall", {15'd0, stall_pc_o}, 16'd1);
    chk("rd_req_addr", ram_addr_o, 16'h0010);
    tick();
    ram_rdata_i = 16'hBEEF; #1;
    chk("rd_instr_nop", instr_o, 16'h0800);
    chk("rd_addr", ram_addr_o, 16'h8000);
    chk("rd_oe_n", {15'd0, ram_oe_n_o}, 16'd0);
    chk("rd_stall", {15'd0, stall_pc_o}, 16'd1);
    chk("rd_done_early", {15'd0, mem_done_o}, 16'd0);
    tick();
    chk("rd_done", {15'd0, mem_done_o}, 16'd1);
    chk("rd_rdata", mem_rdata_o, 16'hBEEF);
    mem_rd_i = 1'b0; #1;
    chk("rd_stall_end", {15'd0, stall_pc_o}, 16'd0);
    tick();
    chk("rd_done_once", {15'd0, mem_done_o}, 16'd0);
    chk("rd_rdata_hold", mem_rdata_o, 16'hBEEF);

    // data write
    mem_wr_i = 1'b1; mem_addr_i = 16'h9000; mem_wdata_i = 16'h00FF; #1;
    chk("wr_req_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("wr_req_wdata", ram_wdata_o, 16'h0000);
    tick();
    chk("wr_setup_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("wr_setup_oe_n", {15'd0, ram_oe_n_o}, 16'd1);
    chk("wr_setup_addr", ram_addr_o, 16'h9000);
    chk("wr_setup_wdata", ram_wdata_o, 16'h00FF);
    tick();
    chk("wr_pulse_we_n", {15'd0, ram_we_n_o}, 16'd0);
    chk("wr_pulse_addr", ram_addr_o, 16'h9000);
    chk("wr_pulse_wdata", ram_wdata_o, 16'h00FF);
    chk("wr_pulse_done", {15'd0, mem_done_o}, 16'd0);
    tick();
    chk("wr_done", {15'd0, mem_done_o}, 16'd1);
    mem_wr_i = 1'b0; #1;
    chk("wr_end_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("wr_end_wdata", ram_wdata_o, 16'h0000);
    chk("wr_end_stall", {15'd0, stall_pc_o}, 16'd0);
    tick();
    chk("wr_done_once", {15'd0, mem_done_o}, 16'd0);

    // rd+wr together is a write, then back-to-back read
    mem_rd_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 16'hA000; mem_wdata_i = 16'h5A5A; tick();
    chk("both_oe_n", {15'd0, ram_oe_n_o}, 16'd1);
    chk("both_wdata", ram_wdata_o, 16'h5A5A);
    tick();
    chk("both_we_n", {15'd0, ram_we_n_o}, 16'd0);
    tick();
    chk("both_done", {15'd0, mem_done_o}, 16'd1);
    mem_wr_i = 1'b0; ram_rdata_i = 16'hC0DE; #1;
    chk("b2b_stall", {15'd0, stall_pc_o}, 16'd1);
    tick();
    chk("b2b_done_low", {15'd0, mem_done_o}, 16'd0);
    chk("b2b_rd_addr", ram_addr_o, 16'hA000);
    chk("b2b_rd_oe_n", {15'd0, ram_oe_n_o}, 16'd0);
    chk("b2b_instr", instr_o, 16'h0800);
    mem_rd_i = 1'b0; tick();
    chk("b2b_done", {15'd0, mem_done_o}, 16'd1);
    chk("b2b_rdata", mem_rdata_o, 16'hC0DE);
    tick();

    // reset in the middle of a write pulse
    mem_wr_i = 1'b1; mem_addr_i = 16'h9000; mem_wdata_i = 16'h1111; tick(); tick();
    chk("rstw_pulse_we_n", {15'd0, ram_we_n_o}, 16'd0);
    RST = 1'b0; mem_wr_i = 1'b0; #1;
    chk("rstw_gate_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("rstw_gate_stall", {15'd0, stall_pc_o}, 16'd1);
    tick();
    chk("rstw_done", {15'd0, mem_done_o}, 16'd0);
    chk("rstw_instr", instr_o, 16'h0800);
    chk("rstw_rdata", mem_rdata_o, 16'h0000);
    RST = 1'b1; #1;
    chk("rstw_we_n", {15'd0, ram_we_n_o}, 16'd1);
    chk("rstw_fetch_addr", ram_addr_o, 16'h0010);
    chk("rstw_fetch_oe_n", {15'd0, ram_oe_n_o}, 16'd0);
    chk("rstw_stall", {15'd0, stall_pc_o}, 16'd0);
    tick();
    chk("rstw_done_after", {15'd0, mem_done_o}, 16'd0);

`ifdef IMEM_WR_PROTECT_EN
    mem_wr_i = 1'b1; mem_addr_i = 16'h0100; mem_wdata_i = 16'h2222; tick(); tick();
    chk("wp_low_we_n", {15'd0, ram_we_n_o}, 16'd1);
    tick();
    chk("wp_low_done", {15'd0, mem_done_o}, 16'd1);
    chk("wp_low_err", {15'd0, wp_err_o}, 16'd1);
    mem_wr_i = 1'b0; tick();
    chk("wp_low_err_once", {15'd0, wp_err_o}, 16'd0);
    mem_wr_i = 1'b1; mem_addr_i = 16'h4000; tick(); tick();
    chk("wp_hi_we_n", {15'd0, ram_we_n_o}, 16'd0);
    tick();
    chk("wp_hi_done", {15'd0, mem_done_o}, 16'd1);
    chk("wp_hi_err", {15'd0, wp_err_o}, 16'd0);
    mem_wr_i = 1'b0; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RST  input  1  reset; synchronous, active-low (0 = reset, sampled on CLK rising edge).
REQ-003 SHALL have port pc_i  input  16  fetch address from the instruction-fetch stage.
REQ-004 SHALL have port flush_i  input  1  fetch-stage misprediction flush; next instr_o becomes NOP.
REQ-005 SHALL have port instr_o  output  16  registered instruction word returned to fetch.
REQ-006 SHALL have port stall_pc_o  output  1  fetch must hold PC this cycle.
REQ-007 SHALL have port mem_rd_i  input  1  data-side read request, held until mem_done_o.
REQ-008 SHALL have port mem_wr_i  input  1  data-side write request, held until mem_done_o.
REQ-009 SHALL have port mem_addr_i  input  16  data-side address.
REQ-010 SHALL have port mem_wdata_i  input  16  data-side write data.
REQ-011 SHALL have port mem_rdata_o  output  16  registered data-side read result.
REQ-012 SHALL have port mem_done_o  output  1  one-cycle completion pulse for a data request.
REQ-013 SHALL have ports ram_addr_o (output 16), ram_wdata_o (output 16), ram_rdata_i (input 16), ram_oe_n_o (output 1), ram_we_n_o (output 1): shared single-port SRAM, strobes active-low.

Function
REQ-014 SHALL implement FSM states FETCH, D_RD, D_WR_SETUP, D_WR_PULSE.
REQ-015 In FETCH: ram_addr_o=pc_i, ram_oe_n_o=0, ram_we_n_o=1.
REQ-016 In FETCH with no request and flush_i=0: instr_o <= ram_rdata_i at edge (1-cycle latency from pc_i).
REQ-017 In FETCH with flush_i=1: instr_o <= NOP 16'h0800.
REQ-018 stall_pc_o SHALL be 1 when state!=FETCH or (state==FETCH and (mem_rd_i or mem_wr_i)); otherwise 0 (combinational).
REQ-019 FETCH with mem_wr_i=1 -> D_WR_SETUP; with mem_rd_i=1 only -> D_RD; instr_o <= NOP on that edge.
REQ-020 mem_rd_i and mem_wr_i both 1 SHALL be treated as a write.
REQ-021 D_RD: ram_addr_o=mem_addr_i, oe_n=0, we_n=1; at edge mem_rdata_o <= ram_rdata_i, mem_done_o <= 1, -> FETCH.
REQ-022 D_WR_SETUP: ram_addr_o=mem_addr_i, ram_wdata_o=mem_wdata_i, oe_n=1, we_n=1; -> D_WR_PULSE.
REQ-023 D_WR_PULSE: same address/data, oe_n=1, we_n=0; at edge mem_done_o <= 1, -> FETCH.
REQ-024 mem_done_o SHALL be high exactly one cycle per request; instr_o holds NOP while not in FETCH.
REQ-025 A request still asserted in the cycle mem_done_o is high SHALL be treated as a new request (back-to-back allowed, fetch starves).
REQ-026 ram_wdata_o SHALL be 0 outside write states.

Reset
REQ-027 RST=0 at an edge SHALL force state FETCH, instr_o=16'h0800, mem_rdata_o=0, mem_done_o=0, regardless of current state (including mid-write; the we_n pulse is abandoned).
REQ-028 While RST=0, stall_pc_o SHALL be 1 and ram_we_n_o SHALL be 1.

Configuration
REQ-029 Macro IMEM_WR_PROTECT_EN: when defined, writes with mem_addr_i < 16'h4000 SHALL keep ram_we_n_o=1 in D_WR_PULSE, still pulse mem_done_o, and pulse output wp_err_o (1 bit, reset 0) for the same cycle; when undefined, wp_err_o does not exist and all writes proceed.

Verification
REQ-030 Reset, pc_i=0x0010, ram_rdata_i=0x1234 -> next cycle instr_o=0x1234, stall_pc_o=0.
REQ-031 FETCH, flush_i=1, ram_rdata_i=0x17FF -> instr_o=0x0800.
REQ-032 mem_rd_i=1, mem_addr_i=0x8000, ram_rdata_i=0xBEEF in D_RD -> ram_addr_o=0x8000, mem_rdata_o=0xBEEF, mem_done_o 1 cycle, stall_pc_o high 2 cycles.
REQ-033 mem_wr_i=1, addr 0x9000, wdata 0x00FF -> we_n low exactly one cycle (third cycle), data/address stable setup+pulse, done pulse, return to FETCH.
REQ-034 RST=0 during D_WR_PULSE -> next cycle we_n=1, state FETCH, instr_o=0x0800, no mem_done_o.
REQ-035 IMEM_WR_PROTECT_EN defined, write to 0x0100 -> we_n stays 1, mem_done_o and wp_err_o pulse together; write to 0x4000 -> normal we_n pulse, wp_err_o=0.
